dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Schedules decoded instructions into the reservation station (RS) and load/store buffer (LSB).
//  - Holds one decoded instruction in a single-entry stage.
//  - Tracks free-entry credits for the RS, LSB and ROB.
//  - Allocates the ROB tail index and pulses exactly one of rs_ins_flag / lsb_ins_flag.
//  - Sits between the decoder and RS/LSB/ROB, so the RS and LSB never see an insert while full.
// PARAMETERS
//  INS_W     6   instruction-type code width
//  XLEN      32  operand/immediate width
//  ROB_ID_W  4   ROB index width
//  RS_SIZE   16  RS entries
//  LSB_SIZE  16  LSB entries
//  ROB_SIZE  16  ROB entries (= 2**ROB_ID_W)
// PORTS
//  clk           in   1         clock, all state on posedge
//  rst           in   1         synchronous, active-high reset
//  rdy           in   1         global enable; 0 freezes all state
//  jp_wrong      in   1         mispredict flush
//  dec_valid     in   1         decoder presents an instruction
//  dec_ready     out  1         stage accepts this cycle
//  dec_insty     in   INS_W     instruction type
//  dec_is_mem    in   1         1 = load/store, routes to LSB
//  dec_rs1_ready in   1         reg1 holds a value (else a ROB id)
//  dec_rs2_ready in   1         reg2 holds a value (else a ROB id)
//  dec_reg1      in   XLEN      operand 1 value or ROB id
//  dec_reg2      in   XLEN      operand 2 value or ROB id
//  dec_imm       in   XLEN      immediate
//  rs_issue      in   1         RS freed one entry (its ALU issue flag)
//  lsb_release   in   1         LSB freed one entry
//  lsb_keep      in   5         committed LSB entries surviving a flush
//  rob_commit    in   1         ROB retired one entry
//  rs_ins_flag   out  1         insert into RS this cycle
//  lsb_ins_flag  out  1         insert into LSB this cycle
//  rob_alloc     out  1         ROB allocates the tail this cycle
//  new_ROB_idx   out  ROB_ID_W  ROB index of the dispatched instruction
//  out_insty, out_rs1_ready, out_rs2_ready, out_reg1, out_reg2, out_imm
//                out  —         held fields; widths match the dec_* ports
// BEHAVIOUR
//  - Reset or flush:
//    - hold_v=0, rs_cnt=0, rob_cnt=0, tail=0, state=RUN.
//    - lsb_cnt=0 on reset; lsb_cnt=lsb_keep on flush.
//  - Reset output values: dec_ready=0, all *_flag=0, new_ROB_idx=0, out_* don't-care (hold regs hold 0).
//  - rdy=0: no register changes; dec_ready=0; all flags 0.
//  - States:
//    - RUN: normal operation.
//    - FLUSH: entered on jp_wrong; lasts exactly 1 cycle, with dec_ready=0 and no dispatch; then RUN.
//    - jp_wrong takes priority over every other event in the same cycle; a jp_wrong arriving in FLUSH restarts FLUSH.
//  - Dispatch conditions (combinational from registers only; no same-cycle credit bypass):
//    - room = dec_is_mem_h ? (lsb_cnt < LSB_SIZE) : (rs_cnt < RS_SIZE).
//    - disp = RUN & rdy & !jp_wrong & hold_v & room & (rob_cnt < ROB_SIZE).
//  - Dispatch outputs:
//    - rs_ins_flag = disp & !mem.
//    - lsb_ins_flag = disp & mem.
//    - rob_alloc = disp.
//    - new_ROB_idx = tail; out_* = hold regs.
//  - Handshake:
//    - dec_ready = RUN & rdy & !jp_wrong & (!hold_v | disp).
//    - dec_valid & dec_ready loads the hold regs next edge; a held entry is never overwritten before dispatch.
//    - Throughput is 1/cycle.
//  - Counters (width clog2(SIZE)+1):
//    - rs_cnt  += disp&!mem − rs_issue.
//    - lsb_cnt += disp&mem − lsb_release.
//    - rob_cnt += disp − rob_commit.
//    - Simultaneous inc+dec leaves the count unchanged.
//    - A dec at 0 is a protocol error: saturate at 0 and fire a sim-only assertion.
//  - tail wraps modulo ROB_SIZE (15 → 0); it advances only on disp.
//  - Full stall: hold_v stays 1 and the fields stay stable until room; dec_ready=0.
// STRUCTURE
//  - Shared package (defines): ILEN/RLEN/RBID widths, RS_SIZE, LSB_SIZE, ROB_SIZE, True/False.
//  - One sub-module: credit_counter (params SIZE; ports inc, dec, load, load_val, cnt, has_room).
//    Instantiated 3×: RS, LSB, ROB.
//  - The FSM, hold register and tail pointer stay in the top level.
// TESTING
//  1. rst=1 for 2 cycles -> dec_ready=0, all flags 0; first cycle after rst, dec_ready=1 and new_ROB_idx=0.
//  2. 3 back-to-back ALU instructions (dec_is_mem=0, rs_issue=0) -> rs_ins_flag on 3 consecutive cycles.
//     new_ROB_idx 0, 1, 2; rs_cnt=3.
//  3. Fill RS with 16 instructions without rs_issue -> 17th held, rs_ins_flag=0, dec_ready=0.
//     Pulse rs_issue -> 17th dispatched next cycle.
//  4. 17 dispatches with rob_commit each cycle after the first -> new_ROB_idx wraps 15 → 0; no stall.
//  5. Mid-stream jp_wrong with lsb_keep=3 and hold_v=1 -> next cycle FLUSH: dec_ready=0, no flags.
//     Then RUN with lsb_cnt=3, rs_cnt=0, new_ROB_idx=0; the held instruction is dropped.
//  6. rdy=0 for 4 cycles while holding a dispatchable instruction -> no flags, counters frozen.
//     rdy=1 -> dispatch on the first cycle.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// Shared widths, queue sizes and state encoding for the dispatch stage.
// Constants only; no logic.
package dispatch_ctrl_pkg;

  localparam int ILEN     = 6;
  localparam int RLEN     = 32;
  localparam int RBID     = 4;
  localparam int RS_SIZE  = 16;
  localparam int LSB_SIZE = 16;
  localparam int ROB_SIZE = 1 << RBID;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } disp_state_e;

endpackage

// File: rtl/credit_counter.sv
// Occupancy counter for one downstream queue; has_room is registered-state only (no bypass).
// Updates one edge after inc/dec; a flush load wins over inc/dec; frozen while en=0.
module credit_counter #(
  parameter int SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   load,
  input  logic [$clog2(SIZE):0]  load_val,
  output logic [$clog2(SIZE):0]  cnt,
  output logic                   has_room
);

  localparam int CW = $clog2(SIZE) + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (inc && !dec) begin
        cnt <= cnt + CW'(1);
      end else if (dec && !inc && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign has_room = (cnt < CW'(SIZE));

  // A release with nothing outstanding means the neighbour lost track of its credits.
  assert property (@(posedge clk) disable iff (rst)
    (en && dec && !inc && !load) |-> (cnt != '0));

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch stage routing decoded instructions to RS or LSB and allocating ROB tails.
// Insert flags fire the cycle after acceptance; dec_ready drops while the held entry lacks credits or during flush.
module dispatch_ctrl #(
  parameter int INS_W    = dispatch_ctrl_pkg::ILEN,
  parameter int XLEN     = dispatch_ctrl_pkg::RLEN,
  parameter int ROB_ID_W = dispatch_ctrl_pkg::RBID,
  parameter int RS_SIZE  = dispatch_ctrl_pkg::RS_SIZE,
  parameter int LSB_SIZE = dispatch_ctrl_pkg::LSB_SIZE,
  parameter int ROB_SIZE = dispatch_ctrl_pkg::ROB_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       jp_wrong,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [INS_W-1:0]           dec_insty,
  input  logic                       dec_is_mem,
  input  logic                       dec_rs1_ready,
  input  logic                       dec_rs2_ready,
  input  logic [XLEN-1:0]            dec_reg1,
  input  logic [XLEN-1:0]            dec_reg2,
  input  logic [XLEN-1:0]            dec_imm,
  input  logic                       rs_issue,
  input  logic                       lsb_release,
  input  logic [$clog2(LSB_SIZE):0]  lsb_keep,
  input  logic                       rob_commit,
  output logic                       rs_ins_flag,
  output logic                       lsb_ins_flag,
  output logic                       rob_alloc,
  output logic [ROB_ID_W-1:0]        new_ROB_idx,
  output logic [INS_W-1:0]           out_insty,
  output logic                       out_rs1_ready,
  output logic                       out_rs2_ready,
  output logic [XLEN-1:0]            out_reg1,
  output logic [XLEN-1:0]            out_reg2,
  output logic [XLEN-1:0]            out_imm
);

  import dispatch_ctrl_pkg::*;

  localparam int RS_CW  = $clog2(RS_SIZE) + 1;
  localparam int LSB_CW = $clog2(LSB_SIZE) + 1;
  localparam int ROB_CW = $clog2(ROB_SIZE) + 1;

  typedef struct packed {
    logic [INS_W-1:0] insty;
    logic             is_mem;
    logic             rs1_ready;
    logic             rs2_ready;
    logic [XLEN-1:0]  reg1;
    logic [XLEN-1:0]  reg2;
    logic [XLEN-1:0]  imm;
  } hdr_t;

  disp_state_e         state, state_nxt;
  hdr_t                hold, dec_hdr;
  logic                hold_v;
  logic [ROB_ID_W-1:0] tail;
  logic                flush, disp, room;
  logic                rs_room, lsb_room, rob_room;
  logic [RS_CW-1:0]    rs_cnt;
  logic [LSB_CW-1:0]   lsb_cnt;
  logic [ROB_CW-1:0]   rob_cnt;

  assign dec_hdr = '{insty: dec_insty, is_mem: dec_is_mem, rs1_ready: dec_rs1_ready,
                     rs2_ready: dec_rs2_ready, reg1: dec_reg1, reg2: dec_reg2, imm: dec_imm};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // Credits are judged from registered counts only, so a release this cycle helps next cycle.
  always_comb begin
    state_nxt    = jp_wrong ? FLUSH : RUN;
    flush        = !rst && rdy && jp_wrong;
    room         = hold.is_mem ? lsb_room : rs_room;
    disp         = !rst && (state == RUN) && rdy && !jp_wrong && hold_v && room && rob_room;
    dec_ready    = !rst && (state == RUN) && rdy && !jp_wrong && (!hold_v || disp);
    rs_ins_flag  = disp && !hold.is_mem;
    lsb_ins_flag = disp && hold.is_mem;
    rob_alloc    = disp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= False;
      hold   <= '0;
      tail   <= '0;
    end else if (rdy) begin
      if (jp_wrong) begin
        hold_v <= False;
        tail   <= '0;
      end else begin
        if (disp) tail <= tail + ROB_ID_W'(1);
        if (dec_valid && dec_ready) begin
          hold   <= dec_hdr;
          hold_v <= True;
        end else if (disp) begin
          hold_v <= False;
        end
      end
    end
  end

  credit_counter #(.SIZE(RS_SIZE)) u_rs_credit (
    .clk(clk), .rst(rst), .en(rdy), .inc(rs_ins_flag), .dec(rs_issue),
    .load(flush), .load_val('0), .cnt(rs_cnt), .has_room(rs_room)
  );

  // Committed stores survive a mispredict, so the LSB restarts from the surviving count.
  credit_counter #(.SIZE(LSB_SIZE)) u_lsb_credit (
    .clk(clk), .rst(rst), .en(rdy), .inc(lsb_ins_flag), .dec(lsb_release),
    .load(flush), .load_val(lsb_keep), .cnt(lsb_cnt), .has_room(lsb_room)
  );

  credit_counter #(.SIZE(ROB_SIZE)) u_rob_credit (
    .clk(clk), .rst(rst), .en(rdy), .inc(rob_alloc), .dec(rob_commit),
    .load(flush), .load_val('0), .cnt(rob_cnt), .has_room(rob_room)
  );

  assert property (@(posedge clk) disable iff (rst)
    (rs_cnt <= RS_CW'(RS_SIZE)) && (lsb_cnt <= LSB_CW'(LSB_SIZE)) && (rob_cnt <= ROB_CW'(ROB_SIZE)));

  assign new_ROB_idx   = tail;
  assign out_insty     = hold.insty;
  assign out_rs1_ready = hold.rs1_ready;
  assign out_rs2_ready = hold.rs2_ready;
  assign out_reg1      = hold.reg1;
  assign out_reg2      = hold.reg2;
  assign out_imm       = hold.imm;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios plus random traffic against an occupancy-count model.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jp_wrong, dec_valid, dec_ready;
  logic [5:0]  dec_insty;
  logic        dec_is_mem, dec_rs1_ready, dec_rs2_ready;
  logic [31:0] dec_reg1, dec_reg2, dec_imm;
  logic        rs_issue, lsb_release, rob_commit;
  logic [4:0]  lsb_keep;
  logic        rs_ins_flag, lsb_ins_flag, rob_alloc;
  logic [3:0]  new_ROB_idx;
  logic [5:0]  out_insty;
  logic        out_rs1_ready, out_rs2_ready;
  logic [31:0] out_reg1, out_reg2, out_imm;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_insty(dec_insty),
    .dec_is_mem(dec_is_mem), .dec_rs1_ready(dec_rs1_ready), .dec_rs2_ready(dec_rs2_ready),
    .dec_reg1(dec_reg1), .dec_reg2(dec_reg2), .dec_imm(dec_imm),
    .rs_issue(rs_issue), .lsb_release(lsb_release), .lsb_keep(lsb_keep), .rob_commit(rob_commit),
    .rs_ins_flag(rs_ins_flag), .lsb_ins_flag(lsb_ins_flag), .rob_alloc(rob_alloc),
    .new_ROB_idx(new_ROB_idx), .out_insty(out_insty), .out_rs1_ready(out_rs1_ready),
    .out_rs2_ready(out_rs2_ready), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm)
  );

  wire [7:0]   obs_vec = {dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc, new_ROB_idx};
  wire [103:0] obs_fld = {out_insty, out_rs1_ready, out_rs2_ready, out_reg1, out_reg2, out_imm};

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy counts, the held instruction and a flush flag.
  int          m_rs = 0, m_lsb = 0, m_rob = 0, m_tail = 0;
  bit          m_hold_v = 0, m_flush = 0, m_mem = 0;
  logic [103:0] m_fld = '0;
  bit          e_disp, e_ready;
  logic [7:0]  e_vec;
  logic [103:0] e_fld;

  task automatic model_eval();
    bit room;
    room    = m_mem ? (m_lsb < 16) : (m_rs < 16);
    e_disp  = !rst && rdy && !m_flush && !jp_wrong && m_hold_v && room && (m_rob < 16);
    e_ready = !rst && rdy && !m_flush && !jp_wrong && (!m_hold_v || e_disp);
    e_vec   = {e_ready, e_disp && !m_mem, e_disp && m_mem, e_disp, 4'(m_tail)};
    e_fld   = m_fld;
  endtask

  task automatic model_step();
    model_eval();
    if (rst) begin
      m_rs = 0; m_lsb = 0; m_rob = 0; m_tail = 0; m_hold_v = 0; m_flush = 0; m_fld = '0; m_mem = 0;
    end else if (rdy) begin
      if (jp_wrong) begin
        m_flush = 1; m_hold_v = 0; m_rs = 0; m_rob = 0; m_tail = 0; m_lsb = int'(lsb_keep);
      end else begin
        m_flush = 0;
        m_rs  = m_rs  + int'(e_disp && !m_mem) - int'(rs_issue);
        m_lsb = m_lsb + int'(e_disp && m_mem)  - int'(lsb_release);
        m_rob = m_rob + int'(e_disp)           - int'(rob_commit);
        if (m_rs < 0) m_rs = 0;
        if (m_lsb < 0) m_lsb = 0;
        if (m_rob < 0) m_rob = 0;
        if (e_disp) m_tail = (m_tail + 1) % 16;
        if (dec_valid && e_ready) begin
          m_hold_v = 1;
          m_mem    = dec_is_mem;
          m_fld    = {dec_insty, dec_rs1_ready, dec_rs2_ready, dec_reg1, dec_reg2, dec_imm};
        end else if (e_disp) begin
          m_hold_v = 0;
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; jp_wrong = 0; dec_valid = 0; dec_is_mem = 0;
    rs_issue = 0; lsb_release = 0; rob_commit = 0; lsb_keep = '0;
  endtask

  task automatic rnd_fields(input bit mem);
    dec_is_mem    = mem;
    dec_insty     = 6'($urandom);
    dec_rs1_ready = 1'($urandom);
    dec_rs2_ready = 1'($urandom);
    dec_reg1      = $urandom;
    dec_reg2      = $urandom;
    dec_imm       = $urandom;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (2) begin at_neg(); at_pos(); end
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rnd_fields(0);
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      checks++;
      if ({dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got rdy/flags %b want 0000",
                 i, {dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc});
      end
      at_pos();
    end
    rst = 0;
    at_neg();
    checks++;
    if (obs_vec !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_exit: got %b want 10000000", obs_vec);
    end
    at_pos();
  endtask

  task automatic test_back_to_back();
    int nflag = 0, first = -1;
    int idxs[3];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      dec_valid = (i < 3);
      rnd_fields(0);
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      if (rs_ins_flag === 1'b1) begin
        if (nflag < 3) idxs[nflag] = int'(new_ROB_idx);
        if (first < 0) first = i;
        nflag++;
      end
      at_pos();
    end
    checks++;
    if (nflag != 3 || first != 1 || idxs[0] != 0 || idxs[1] != 1 || idxs[2] != 2) begin
      errors++;
      $display("FAIL b2b_seq: got n=%0d first=%0d idx=%0d,%0d,%0d want n=3 first=1 idx=0,1,2",
               nflag, first, idxs[0], idxs[1], idxs[2]);
    end
  endtask

  task automatic test_rs_full();
    int sent = 0, nflag = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      dec_valid  = (sent < 17);
      rs_issue   = (i == 22);
      rob_commit = (m_rob > 0);
      rnd_fields(0);
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL rs_full cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      if (i == 21) begin
        checks++;
        if (nflag != 16 || dec_ready !== 1'b0 || rs_ins_flag !== 1'b0) begin
          errors++;
          $display("FAIL rs_full_stall: got n=%0d rdy=%b flag=%b want n=16 rdy=0 flag=0",
                   nflag, dec_ready, rs_ins_flag);
        end
      end
      if (i == 23) begin
        checks++;
        if (rs_ins_flag !== 1'b1) begin
          errors++;
          $display("FAIL rs_full_resume: got flag=%b want 1", rs_ins_flag);
        end
      end
      if (dec_valid && dec_ready) sent++;
      if (rs_ins_flag === 1'b1) nflag++;
      at_pos();
    end
  endtask

  task automatic test_rob_wrap();
    int nflag = 0, last = -1;
    int idxs[17];
    do_reset();
    for (int i = 0; i < 19; i++) begin
      dec_valid  = (i < 17);
      rs_issue   = (m_rs > 0);
      rob_commit = (m_rob > 0);
      rnd_fields(0);
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL rob_wrap cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      if (rob_alloc === 1'b1) begin
        if (nflag < 17) idxs[nflag] = int'(new_ROB_idx);
        nflag++;
        last = i;
      end
      at_pos();
    end
    checks++;
    if (nflag != 17 || last != 17 || idxs[15] != 15 || idxs[16] != 0) begin
      errors++;
      $display("FAIL rob_wrap_seq: got n=%0d last=%0d idx15=%0d idx16=%0d want 17 17 15 0",
               nflag, last, idxs[15], idxs[16]);
    end
  endtask

  task automatic test_flush();
    int sent = 0, nflag = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      jp_wrong   = (i == 5);
      lsb_keep   = 5'd3;
      rob_commit = (i >= 8) && (m_rob > 0);
      if (i < 7) begin
        dec_valid = 1;
        rnd_fields(i % 2 == 1);
      end else if (i == 7) begin
        dec_valid = 0;
      end else begin
        dec_valid = (sent < 14);
        rnd_fields(1);
      end
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL flush cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      if (i == 5 || i == 6) begin
        checks++;
        if ({dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc} !== 4'b0000) begin
          errors++;
          $display("FAIL flush_quiet cyc %0d: got %b want 0000",
                   i, {dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc});
        end
      end
      if (i == 7) begin
        checks++;
        if (obs_vec !== 8'b1000_0000) begin
          errors++;
          $display("FAIL flush_exit: got %b want 10000000", obs_vec);
        end
      end
      if (i >= 8 && dec_valid && dec_ready) sent++;
      if (i >= 8 && lsb_ins_flag === 1'b1) nflag++;
      if (i == 24) begin
        checks++;
        if (nflag != 13 || dec_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_lsb_keep: got n=%0d rdy=%b want n=13 rdy=0", nflag, dec_ready);
        end
      end
      at_pos();
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rdy        = !(i >= 2 && i <= 5);
      dec_valid  = (i <= 5);
      rs_issue   = !rdy && (m_rs > 0);
      rob_commit = !rdy && (m_rob > 0);
      rnd_fields(0);
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL rdy cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if ({dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc} !== 4'b0000) begin
          errors++;
          $display("FAIL rdy_frozen cyc %0d: got %b want 0000",
                   i, {dec_ready, rs_ins_flag, lsb_ins_flag, rob_alloc});
        end
      end
      if (i == 6) begin
        checks++;
        if (rs_ins_flag !== 1'b1 || new_ROB_idx !== 4'd1) begin
          errors++;
          $display("FAIL rdy_resume: got flag=%b idx=%0d want flag=1 idx=1", rs_ins_flag, new_ROB_idx);
        end
      end
      at_pos();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      jp_wrong    = ($urandom_range(0, 24) == 0);
      lsb_keep    = 5'($urandom_range(0, 16));
      dec_valid   = ($urandom_range(0, 9) < 7);
      rs_issue    = (m_rs > 0) && ($urandom_range(0, 9) < 3);
      lsb_release = (m_lsb > 0) && ($urandom_range(0, 9) < 3);
      rob_commit  = (m_rob > 0) && ($urandom_range(0, 9) < 4);
      rnd_fields(1'($urandom));
      at_neg();
      checks++;
      if (obs_vec !== e_vec || (e_disp && obs_fld !== e_fld)) begin
        errors++;
        $display("FAIL random cyc %0d: got %b/%h want %b/%h", i, obs_vec, obs_fld, e_vec, e_fld);
      end
      at_pos();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_rs_full();
    test_rob_wrap();
    test_flush();
    test_rdy_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
